// File: rtl/sbqm_pkg.sv
// Shared constants and the sensor FSM state type for the SBqM queue counter.
package sbqm_pkg;

    localparam int N_DEF      = 3;
    localparam int TW         = 2;
    localparam int ADDR_W_DEF = N_DEF + TW;
    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEB_ON  = 2'd1,
        BLOCKED = 2'd2,
        DEB_OFF = 2'd3
    } sns_state_e;

endpackage

// File: rtl/sensor_fsm.sv
// One photocell channel: 2-flop synchroniser, debounce FSM and a one-cycle
// registered evt pulse per complete blocked-then-cleared beam cycle.
module sensor_fsm
    import sbqm_pkg::*;
#(
    parameter int DEB_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sns,
    output logic evt
);

    localparam logic [3:0] LAST = 4'(DEB_CYC - 1);

    logic [SYNC_DEPTH-1:0] sync;
    logic                  s;
    sns_state_e            state, state_d;
    logic [3:0]            cnt, cnt_d;
    logic                  evt_d;

    assign s = sync[SYNC_DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            state <= IDLE;
            cnt   <= '0;
            evt   <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_DEPTH-2:0], sns};
            state <= state_d;
            cnt   <= cnt_d;
            evt   <= evt_d;
        end
    end

    // With DEB_CYC=1 the debounce states are skipped entirely
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        evt_d   = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    if (DEB_CYC == 1) begin
                        state_d = BLOCKED;
                    end else begin
                        state_d = DEB_ON;
                        cnt_d   = 4'd1;
                    end
                end
            end
            DEB_ON: begin
                if (!s)              state_d = IDLE;
                else if (cnt == LAST) state_d = BLOCKED;
                else                 cnt_d   = cnt + 4'd1;
            end
            BLOCKED: begin
                if (!s) begin
                    if (DEB_CYC == 1) begin
                        state_d = IDLE;
                        evt_d   = 1'b1;
                    end else begin
                        state_d = DEB_OFF;
                        cnt_d   = 4'd1;
                    end
                end
            end
            DEB_OFF: begin
                if (s) begin
                    state_d = BLOCKED;
                end else if (cnt == LAST) begin
                    state_d = IDLE;
                    evt_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/queue_counter.sv
// SBqM queue occupancy counter feeding the wait-time ROM address.
// Optional sticky overflow/underflow flags are built when SBQM_ERR_EN is defined.
module queue_counter
    import sbqm_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DEB_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            front_sns,
    input  logic            back_sns,
    input  logic [TW-1:0]   Tcount,
    input  logic            err_clr,
    output logic [N-1:0]    Pcount,
    output logic [TW-1:0]   Tcount_q,
    output logic [N+TW-1:0] Adress,
    output logic            full_flag,
    output logic            empty_flag,
    output logic            rej,
    output logic            err_ovf,
    output logic            err_unf
);

    localparam logic [N-1:0] ONE  = 1;
    localparam logic [N-1:0] PMAX = '1;

    logic in_evt, out_evt;
    logic ovf_set, unf_set;

    sensor_fsm #(.DEB_CYC(DEB_CYC)) u_front (
        .clk (clk),
        .rst (rst),
        .sns (front_sns),
        .evt (in_evt)
    );

    sensor_fsm #(.DEB_CYC(DEB_CYC)) u_back (
        .clk (clk),
        .rst (rst),
        .sns (back_sns),
        .evt (out_evt)
    );

    assign full_flag  = (Pcount == PMAX);
    assign empty_flag = (Pcount == '0);
    assign Adress     = {Pcount, Tcount_q};

    // Simultaneous entry and exit cancel, so neither error condition applies
    assign ovf_set = in_evt & ~out_evt & full_flag;
    assign unf_set = out_evt & ~in_evt & empty_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Pcount   <= '0;
            Tcount_q <= '0;
            rej      <= 1'b0;
        end else begin
            Tcount_q <= Tcount;
            rej      <= ovf_set;
            if (in_evt && !out_evt && !full_flag)
                Pcount <= Pcount + ONE;
            else if (out_evt && !in_evt && !empty_flag)
                Pcount <= Pcount - ONE;
        end
    end

`ifdef SBQM_ERR_EN
    // A new error in the same cycle as err_clr must not be lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            err_ovf <= ovf_set | (err_ovf & ~err_clr);
            err_unf <= unf_set | (err_unf & ~err_clr);
        end
    end
`else
    logic unused_err;
    assign unused_err = err_clr ^ ovf_set ^ unf_set;
    assign err_ovf    = 1'b0;
    assign err_unf    = 1'b0;
`endif

endmodule

// File: tb/tb_queue_counter.sv
// Self-checking bench for queue_counter (N=3, DEB_CYC=2) against a counting model.
module tb_queue_counter;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         front_sns = 1'b0;
    logic         back_sns = 1'b0;
    logic [1:0]   Tcount = 2'd0;
    logic         err_clr = 1'b0;
    logic [N-1:0] Pcount;
    logic [1:0]   Tcount_q;
    logic [N+1:0] Adress;
    logic         full_flag, empty_flag, rej, err_ovf, err_unf;

    int vectors = 0;
    int miscompares = 0;

`ifdef SBQM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int model_pc  = 0;
    bit model_ovf = 1'b0;
    bit model_unf = 1'b0;

    queue_counter #(.N(N), .DEB_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .front_sns  (front_sns),
        .back_sns   (back_sns),
        .Tcount     (Tcount),
        .err_clr    (err_clr),
        .Pcount     (Pcount),
        .Tcount_q   (Tcount_q),
        .Adress     (Adress),
        .full_flag  (full_flag),
        .empty_flag (empty_flag),
        .rej        (rej),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
    );

    always #5 clk = ~clk;

    // Stimulus only: one person (or glitch) on the chosen sensors, then a
    // settling window; counts rej pulses seen over the whole operation.
    task automatic person(input bit f, input bit b, input int hi, output int rejs);
        rejs = 0;
        for (int i = 0; i < hi; i++) begin
            @(negedge clk);
            if (rej === 1'b1) rejs++;
            front_sns = f;
            back_sns  = b;
        end
        @(negedge clk);
        if (rej === 1'b1) rejs++;
        front_sns = 1'b0;
        back_sns  = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (rej === 1'b1) rejs++;
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (Pcount !== 3'd0 || empty_flag !== 1'b1 || full_flag !== 1'b0 || Adress !== 5'd0 ||
            rej !== 1'b0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: Pcount=%0d empty=%b full=%b Adress=%b rej=%b ovf=%b unf=%b, want 0 1 0 00000 0 0 0",
                     Pcount, empty_flag, full_flag, Adress, rej, err_ovf, err_unf);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (Pcount !== 3'd0 || empty_flag !== 1'b1 || full_flag !== 1'b0 || Adress !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_async: Pcount=%0d empty=%b full=%b Adress=%b, want 0 1 0 00000",
                     Pcount, empty_flag, full_flag, Adress);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_entry();
        Tcount = 2'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            front_sns = 1'b1;
        end
        @(negedge clk);
        front_sns = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (Pcount !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL entry_early: Pcount=%0d after 4 edges, want 0", Pcount);
        end
        @(negedge clk);
        vectors++;
        if (Pcount !== 3'd1 || Adress !== 5'b00110 || empty_flag !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL entry_latency: Pcount=%0d Adress=%b empty=%b after 5 edges, want 1 00110 0",
                     Pcount, Adress, empty_flag);
        end
        model_pc = 1;
    endtask

    task automatic test_glitch();
        int rejs;
        person(1'b1, 1'b0, 1, rejs);
        vectors++;
        if (Pcount !== 3'd1 || rejs != 0) begin
            miscompares++;
            $display("[TB] FAIL glitch: Pcount=%0d rej_pulses=%0d, want 1 0", Pcount, rejs);
        end
    endtask

    task automatic test_full_reject();
        int rejs;
        for (int i = 0; i < 6; i++) person(1'b1, 1'b0, 4, rejs);
        vectors++;
        if (Pcount !== 3'd7 || full_flag !== 1'b1 || rejs != 0) begin
            miscompares++;
            $display("[TB] FAIL fill: Pcount=%0d full=%b rej_pulses=%0d, want 7 1 0", Pcount, full_flag, rejs);
        end
        person(1'b1, 1'b0, 4, rejs);
        vectors++;
        if (Pcount !== 3'd7 || full_flag !== 1'b1 || rejs != 1 || err_ovf !== ERR_EN) begin
            miscompares++;
            $display("[TB] FAIL reject: Pcount=%0d full=%b rej_pulses=%0d ovf=%b, want 7 1 1 %b",
                     Pcount, full_flag, rejs, err_ovf, ERR_EN);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (err_ovf !== ERR_EN) begin
            miscompares++;
            $display("[TB] FAIL ovf_sticky: err_ovf=%b, want %b", err_ovf, ERR_EN);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++;
        if (err_ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_clear: err_ovf=%b, want 0", err_ovf);
        end
        model_pc = 7;
    endtask

    task automatic test_simultaneous();
        int rejs;
        person(1'b1, 1'b1, 4, rejs);
        vectors++;
        if (Pcount !== 3'd7 || rejs != 0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL simultaneous: Pcount=%0d rej_pulses=%0d ovf=%b unf=%b, want 7 0 0 0",
                     Pcount, rejs, err_ovf, err_unf);
        end
    endtask

    task automatic test_underflow();
        int rejs;
        for (int i = 0; i < 7; i++) person(1'b0, 1'b1, 3, rejs);
        vectors++;
        if (Pcount !== 3'd0 || empty_flag !== 1'b1 || err_unf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drain: Pcount=%0d empty=%b unf=%b, want 0 1 0", Pcount, empty_flag, err_unf);
        end
        person(1'b0, 1'b1, 3, rejs);
        vectors++;
        if (Pcount !== 3'd0 || rejs != 0 || err_unf !== ERR_EN) begin
            miscompares++;
            $display("[TB] FAIL underflow: Pcount=%0d rej_pulses=%0d unf=%b, want 0 0 %b",
                     Pcount, rejs, err_unf, ERR_EN);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        model_pc = 0;
    endtask

    task automatic test_reset_mid();
        int rejs;
        person(1'b1, 1'b0, 4, rejs);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            front_sns = 1'b1;
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (Pcount !== 3'd0 || empty_flag !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: Pcount=%0d empty=%b, want 0 1", Pcount, empty_flag);
        end
        @(negedge clk);
        rst = 1'b0;
        person(1'b1, 1'b0, 3, rejs);
        vectors++;
        if (Pcount !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL reset_reblock: Pcount=%0d, want 1", Pcount);
        end
        model_pc  = 1;
        model_ovf = 1'b0;
        model_unf = 1'b0;
    endtask

    task automatic test_random();
        int rejs, op, exp_rej;
        logic [1:0] tc;
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 9));
            tc = 2'($urandom_range(0, 3));
            Tcount = tc;
            exp_rej = 0;
            if (op <= 3) begin
                person(1'b1, 1'b0, int'($urandom_range(2, 5)), rejs);
                if (model_pc == 7) begin
                    exp_rej = 1;
                    model_ovf = ERR_EN;
                end else begin
                    model_pc++;
                end
            end else if (op <= 6) begin
                person(1'b0, 1'b1, int'($urandom_range(2, 5)), rejs);
                if (model_pc == 0) model_unf = ERR_EN;
                else model_pc--;
            end else if (op == 7) begin
                person(1'b1, 1'b1, int'($urandom_range(2, 5)), rejs);
            end else if (op == 8) begin
                person($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, rejs);
            end else begin
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                model_ovf = 1'b0;
                model_unf = 1'b0;
                rejs = 0;
            end
            vectors++;
            if (int'(Pcount) != model_pc || Adress !== {3'(model_pc), tc} ||
                full_flag !== (model_pc == 7) || empty_flag !== (model_pc == 0) || rejs != exp_rej ||
                err_ovf !== model_ovf || err_unf !== model_unf) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] op=%0d: Pcount=%0d Adress=%b full=%b empty=%b rej_pulses=%0d ovf=%b unf=%b, want %0d %b %b %b %0d %b %b",
                         n, op, Pcount, Adress, full_flag, empty_flag, rejs, err_ovf, err_unf,
                         model_pc, {3'(model_pc), tc}, model_pc == 7, model_pc == 0, exp_rej,
                         model_ovf, model_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_glitch();
        test_full_reject();
        test_simultaneous();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
